// File: rtl/pipe_pkg.sv
// Shared definitions for the valid/ready pipeline stage register.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b10
    } pipe_state_t;

    localparam int PIPE_OCC_W = 2;

    // Number of beats held in a given state; an illegal encoding reports 0.
    function automatic logic [PIPE_OCC_W-1:0] pipe_occ(input pipe_state_t s);
        case (s)
            BUSY:    return 2'd1;
            FULL:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with a valid/ready handshake and a one-entry skid
// buffer. in_ready_o and out_valid_o are decoded from the state register
// only, so no combinational path runs from any input to any output.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W        = 64,
    parameter bit ZERO_ON_FLUSH = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    input  logic [DATA_W-1:0]     in_data_i,
    output logic                  in_ready_o,
    output logic                  out_valid_o,
    output logic [DATA_W-1:0]     out_data_o,
    input  logic                  out_ready_i,
    output logic [PIPE_OCC_W-1:0] occ_o
);

    pipe_state_t       state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              in_fire;
    logic              out_fire;

    assign in_ready_o  = (state_q != FULL);
    assign out_valid_o = (state_q != EMPTY);
    assign out_data_o  = main_q;
    assign occ_o       = pipe_occ(state_q);

    assign in_fire  = in_valid_i & in_ready_o;
    assign out_fire = out_valid_o & out_ready_i;

    // Next state and data: flush wins over every handshake event; an
    // incoming beat on a flush cycle is swallowed. Illegal states fall to EMPTY.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = EMPTY;
            if (ZERO_ON_FLUSH) begin
                main_d = '0;
                skid_d = '0;
            end
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = BUSY;
                        main_d  = in_data_i;
                    end
                end
                BUSY: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data_i;
                    end else if (in_fire) begin
                        state_d = FULL;
                        skid_d  = in_data_i;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state_d = BUSY;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // State and both data registers; reset clears everything at once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule
